fix_checksum_gen: RTL and testbench

Parametrised FIX tag-10 checksum generator. It accepts a FIX message as a stream of 1..8 bytes per beat and sums every kept byte modulo 256. At end of message it emits the result as three ASCII decimal digits, or optionally as the full trailer "10=ddd<SOH>", one character per handshake. It sits in the transmit path after the message builder and before the serializer, and is the multi-byte, back-pressured successor of the single-byte checksum block.

---
 rtl/fix_checksum_gen_pkg.sv | 53 +++++
 rtl/fix_checksum_gen_if.sv | 37 +++
 rtl/fix_checksum_gen_bin2ascii3.sv | 50 +++++
 rtl/fix_checksum_gen.sv | 153 +++++++++++++++
 tb/tb_fix_checksum_gen.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fix_checksum_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fix_cks_pkg
//  Purpose  : Shared types and constants for the FIX tag-10 checksum blocks.
//             Provides the FSM state enum, ASCII constants and the output
//             character selector.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package fix_cks_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  localparam logic [7:0] c_SOH  = 8'h01;
  localparam logic [7:0] c_ZERO = 8'h30;
  localparam logic [7:0] c_EQ   = 8'h3D;
  localparam logic [7:0] c_ONE  = 8'h31;

  // Character at position idx of the emitted sequence: either "ddd" or
  // "10=ddd<SOH>". Digits are already ASCII-encoded.
  function automatic logic [7:0] char_sel(input logic       trailer,
                                          input logic [2:0] idx,
                                          input logic [7:0] d2,
                                          input logic [7:0] d1,
                                          input logic [7:0] d0);
    logic [7:0] c;
    c = d0;
    if (!trailer) begin
      case (idx)
        3'd0:    c = d2;
        3'd1:    c = d1;
        default: c = d0;
      endcase
    end else begin
      case (idx)
        3'd0:    c = c_ONE;
        3'd1:    c = c_ZERO;
        3'd2:    c = c_EQ;
        3'd3:    c = d2;
        3'd4:    c = d1;
        3'd5:    c = d0;
        default: c = c_SOH;
      endcase
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fix_checksum_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : fix_checksum_gen_if
//  Purpose  : Message-in / checksum-out stream bundle for fix_checksum_gen.
//  Signals  : in_valid/in_ready/in_data/in_keep/in_sop/in_eop  (beat stream)
//             cks_valid/cks_ready/cks_char/cks_last/cks_sum     (char stream)
//             err                                               (error pulse)
//  Modports : master = message source / char sink, slave = checksum block
//  Revision : 1.0 - initial release
// ============================================================================
interface fix_checksum_gen_if #(
  parameter int BYTES_PER_BEAT = 1
);
  logic                          in_valid;
  logic                          in_ready;
  logic [8*BYTES_PER_BEAT-1:0]   in_data;
  logic [BYTES_PER_BEAT-1:0]     in_keep;
  logic                          in_sop;
  logic                          in_eop;
  logic                          cks_valid;
  logic                          cks_ready;
  logic [7:0]                    cks_char;
  logic                          cks_last;
  logic [7:0]                    cks_sum;
  logic                          err;

  modport master (
    output in_valid, in_data, in_keep, in_sop, in_eop, cks_ready,
    input  in_ready, cks_valid, cks_char, cks_last, cks_sum, err
  );

  modport slave (
    input  in_valid, in_data, in_keep, in_sop, in_eop, cks_ready,
    output in_ready, cks_valid, cks_char, cks_last, cks_sum, err
  );
endinterface
`default_nettype wire

// File: rtl/fix_checksum_gen_bin2ascii3.sv
`default_nettype none
// ============================================================================
//  Module   : bin2ascii3
//  Purpose  : Combinational 8-bit binary to three ASCII decimal digits,
//             built from compare/subtract steps (no divider).
//  Ports    : i_value [7:0]  binary input 0..255
//             o_d2    [7:0]  ASCII hundreds digit ('0'..'2')
//             o_d1    [7:0]  ASCII tens digit
//             o_d0    [7:0]  ASCII ones digit
//  Revision : 1.0 - initial release
// ============================================================================
module bin2ascii3
  import fix_cks_pkg::*;
(
  input  wire logic [7:0] i_value,
  output logic      [7:0] o_d2,
  output logic      [7:0] o_d1,
  output logic      [7:0] o_d0
);

  logic [1:0] w_hund;
  logic [3:0] w_tens;
  logic [7:0] w_rem;

  always_comb begin
    w_hund = 2'd0;
    w_rem  = i_value;
    if (i_value >= 8'd200) begin
      w_hund = 2'd2;
      w_rem  = i_value - 8'd200;
    end else if (i_value >= 8'd100) begin
      w_hund = 2'd1;
      w_rem  = i_value - 8'd100;
    end
    // Remainder is below 100 here, so at most nine tens can come off.
    w_tens = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (w_rem >= 8'd10) begin
        w_rem  = w_rem - 8'd10;
        w_tens = w_tens + 4'd1;
      end
    end
  end

  assign o_d2 = c_ZERO + {6'd0, w_hund};
  assign o_d1 = c_ZERO + {4'd0, w_tens};
  assign o_d0 = c_ZERO + w_rem;

endmodule
`default_nettype wire

// File: rtl/fix_checksum_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fix_checksum_gen
//  Purpose  : FIX tag-10 checksum generator. Sums kept message bytes mod 256
//             over a multi-byte beat stream and emits the result as "ddd" or
//             as the full "10=ddd<SOH>" trailer, one char per handshake.
//  Params   : BYTES_PER_BEAT (1..8), SEED (start value on sop),
//             TRAILER (0: 3 digits, 1: 7-char trailer)
//  Ports    : clk    rising-edge clock
//             rst_n  asynchronous active-low reset
//             bus    fix_checksum_gen_if.slave (beat in, char out, err)
//  Revision : 1.0 - initial release
// ============================================================================
module fix_checksum_gen
  import fix_cks_pkg::*;
#(
  parameter int         BYTES_PER_BEAT = 1,
  parameter logic [7:0] SEED           = 8'd0,
  parameter int         TRAILER        = 0
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  fix_checksum_gen_if.slave   bus
);

  localparam int         c_SUM_W    = 8 + $clog2(BYTES_PER_BEAT);
  localparam logic       c_TRAILER  = (TRAILER != 0);
  localparam logic [2:0] c_LAST_IDX = (TRAILER != 0) ? 3'd6 : 3'd2;

  state_t     r_state;
  logic [7:0] r_acc;
  logic [2:0] r_cnt;
  logic [7:0] r_d2, r_d1, r_d0;
  logic       r_ready;
  logic       r_cks_valid;
  logic       r_cks_last;
  logic [7:0] r_cks_char;
  logic [7:0] r_cks_sum;
  logic       r_err;

  logic [c_SUM_W-1:0] w_beat_sum;
  logic [7:0]         w_base;
  logic [7:0]         w_acc_next;
  logic [7:0]         w_d2, w_d1, w_d0;
  logic               w_fire;
  logic [2:0]         w_cnt_nxt;

  // Beat adder: full-width sum of kept bytes, reduced mod 256 only when it
  // is folded into the accumulator.
  always_comb begin
    w_beat_sum = '0;
    for (int i = 0; i < BYTES_PER_BEAT; i++) begin
      if (bus.in_keep[i]) begin
        w_beat_sum = w_beat_sum + c_SUM_W'(bus.in_data[8*i +: 8]);
      end
    end
  end

  // A sop beat always restarts from SEED, whichever state accepts it.
  assign w_base     = bus.in_sop ? SEED : r_acc;
  assign w_acc_next = 8'(c_SUM_W'(w_base) + w_beat_sum);
  assign w_fire     = bus.in_valid & r_ready;
  assign w_cnt_nxt  = r_cnt + 3'd1;

  // Digits are taken from the would-be sum so they can be latched together
  // with the final accumulator value on the eop edge.
  bin2ascii3 u_bin2ascii3 (
    .i_value (w_acc_next),
    .o_d2    (w_d2),
    .o_d1    (w_d1),
    .o_d0    (w_d0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= 8'h00;
      r_cnt       <= 3'd0;
      r_d2        <= 8'h00;
      r_d1        <= 8'h00;
      r_d0        <= 8'h00;
      r_ready     <= 1'b0;
      r_cks_valid <= 1'b0;
      r_cks_last  <= 1'b0;
      r_cks_char  <= 8'h00;
      r_cks_sum   <= 8'h00;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE, ACCUM: begin
          r_ready <= 1'b1;
          if (w_fire) begin
            if ((r_state == IDLE) && !bus.in_sop) begin
              // Orphan beat outside a message: drop it.
              r_err <= 1'b1;
            end else begin
              if ((r_state == ACCUM) && bus.in_sop) begin
                r_err <= 1'b1;
              end
              r_acc <= w_acc_next;
              if (bus.in_eop) begin
                r_state     <= EMIT;
                r_ready     <= 1'b0;
                r_cks_valid <= 1'b1;
                r_cks_last  <= 1'b0;
                r_cks_sum   <= w_acc_next;
                r_d2        <= w_d2;
                r_d1        <= w_d1;
                r_d0        <= w_d0;
                r_cnt       <= 3'd0;
                r_cks_char  <= char_sel(c_TRAILER, 3'd0, w_d2, w_d1, w_d0);
              end else begin
                r_state <= ACCUM;
              end
            end
          end
        end

        EMIT: begin
          if (bus.cks_ready) begin
            if (r_cks_last) begin
              r_state     <= IDLE;
              r_ready     <= 1'b1;
              r_cks_valid <= 1'b0;
              r_cks_last  <= 1'b0;
              r_cks_char  <= 8'h00;
              r_cks_sum   <= 8'h00;
              r_cnt       <= 3'd0;
            end else begin
              r_cnt      <= w_cnt_nxt;
              r_cks_char <= char_sel(c_TRAILER, w_cnt_nxt, r_d2, r_d1, r_d0);
              r_cks_last <= (w_cnt_nxt == c_LAST_IDX);
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_ready;
  assign bus.cks_valid = r_cks_valid;
  assign bus.cks_char  = r_cks_char;
  assign bus.cks_last  = r_cks_last;
  assign bus.cks_sum   = r_cks_sum;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fix_checksum_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fix_checksum_gen
//  Purpose  : Directed self-checking bench for fix_checksum_gen. Three
//             instances: 1-byte digits, 4-byte digits, 4-byte trailer.
//             The two 4-byte instances share the same input stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fix_checksum_gen;

  logic       clk;
  logic       rst_n;
  logic [2:0] rdy;
  logic [1:0] sel;
  int         n_checks = 0;
  int         n_errors = 0;

  fix_checksum_gen_if #(.BYTES_PER_BEAT(1)) bus1 ();
  fix_checksum_gen_if #(.BYTES_PER_BEAT(4)) bus4 ();
  fix_checksum_gen_if #(.BYTES_PER_BEAT(4)) bus4t ();

  fix_checksum_gen #(.BYTES_PER_BEAT(1), .SEED(8'd0), .TRAILER(0)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1)
  );
  fix_checksum_gen #(.BYTES_PER_BEAT(4), .SEED(8'd0), .TRAILER(0)) u_dut4 (
    .clk (clk), .rst_n (rst_n), .bus (bus4)
  );
  fix_checksum_gen #(.BYTES_PER_BEAT(4), .SEED(8'd0), .TRAILER(1)) u_dut4t (
    .clk (clk), .rst_n (rst_n), .bus (bus4t)
  );

  assign bus1.cks_ready  = rdy[0];
  assign bus4.cks_ready  = rdy[1];
  assign bus4t.cks_ready = rdy[2];
  assign bus4t.in_valid  = bus4.in_valid;
  assign bus4t.in_data   = bus4.in_data;
  assign bus4t.in_keep   = bus4.in_keep;
  assign bus4t.in_sop    = bus4.in_sop;
  assign bus4t.in_eop    = bus4.in_eop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation mux so one set of tasks serves all three instances.
  logic       m_valid, m_last, m_inrdy, m_err;
  logic [7:0] m_char, m_sum;
  always_comb begin
    case (sel)
      2'd1: begin
        m_valid = bus4.cks_valid; m_last = bus4.cks_last; m_inrdy = bus4.in_ready;
        m_err   = bus4.err;       m_char = bus4.cks_char; m_sum   = bus4.cks_sum;
      end
      2'd2: begin
        m_valid = bus4t.cks_valid; m_last = bus4t.cks_last; m_inrdy = bus4t.in_ready;
        m_err   = bus4t.err;       m_char = bus4t.cks_char; m_sum   = bus4t.cks_sum;
      end
      default: begin
        m_valid = bus1.cks_valid; m_last = bus1.cks_last; m_inrdy = bus1.in_ready;
        m_err   = bus1.err;       m_char = bus1.cks_char; m_sum   = bus1.cks_sum;
      end
    endcase
  end

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic send1(input logic [7:0] d, input logic s, input logic e);
    int w = 0;
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.in_data = d; bus1.in_keep = 1'b1;
    bus1.in_sop   = s;    bus1.in_eop  = e;
    while (!bus1.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check1("send1_ready", bus1.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0; bus1.in_sop = 1'b0; bus1.in_eop = 1'b0;
  endtask

  task automatic send4(input logic [31:0] d, input logic [3:0] k, input logic s, input logic e);
    int w = 0;
    @(negedge clk);
    bus4.in_valid = 1'b1; bus4.in_data = d; bus4.in_keep = k;
    bus4.in_sop   = s;    bus4.in_eop  = e;
    while (!bus4.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check1("send4_ready", bus4.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0; bus4.in_sop = 1'b0; bus4.in_eop = 1'b0;
  endtask

  // Expect n chars (first char in the most significant used byte of seq).
  task automatic collect(input logic [1:0] s, input logic [55:0] seq, input int n,
                         input logic [7:0] sum, input logic stall);
    logic [7:0] ec;
    int         w;
    sel = s;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w = 0;
      while (!m_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      check1("char_valid", m_valid, 1'b1);
      ec = seq[8*(n-1-i) +: 8];
      check8("char", m_char, ec);
      check1("last", m_last, (i == n-1));
      check8("sum", m_sum, sum);
      if (stall) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check8("hold_char", m_char, ec);
          check1("hold_valid", m_valid, 1'b1);
          check1("hold_inrdy", m_inrdy, 1'b0);
        end
      end
      rdy[s] = 1'b1;
      @(posedge clk);
      #1;
      rdy[s] = 1'b0;
    end
    @(negedge clk);
    check1("done_valid", m_valid, 1'b0);
    check1("done_inrdy", m_inrdy, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rdy = 3'b000; sel = 2'd0;
    bus1.in_valid = 1'b0; bus1.in_data = 8'h00; bus1.in_keep = 1'b0;
    bus1.in_sop   = 1'b0; bus1.in_eop  = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = 32'h0; bus4.in_keep = 4'h0;
    bus4.in_sop   = 1'b0; bus4.in_eop  = 1'b0;

    // Reset values
    #3;
    check1("rst_inrdy", bus1.in_ready, 1'b0);
    check1("rst_valid", bus1.cks_valid, 1'b0);
    check8("rst_char", bus1.cks_char, 8'h00);
    check1("rst_last", bus1.cks_last, 1'b0);
    check8("rst_sum", bus1.cks_sum, 8'h00);
    check1("rst_err", bus1.err, 1'b0);
    check1("rst_inrdy4t", bus4t.in_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check1("post_rst_inrdy", bus1.in_ready, 1'b1);

    // "ABC" -> 198
    send1(8'h41, 1'b1, 1'b0);
    send1(8'h42, 1'b0, 1'b0);
    send1(8'h43, 1'b0, 1'b1);
    @(negedge clk);
    check1("abc_valid_t1", bus1.cks_valid, 1'b1);
    check1("abc_inrdy_emit", bus1.in_ready, 1'b0);
    collect(2'd0, 56'h31_39_38, 3, 8'hC6, 1'b0);

    // Wrap: 4 x FF = 1020 -> 252
    send1(8'hFF, 1'b1, 1'b0);
    send1(8'hFF, 1'b0, 1'b0);
    send1(8'hFF, 1'b0, 1'b0);
    send1(8'hFF, 1'b0, 1'b1);
    collect(2'd0, 56'h32_35_32, 3, 8'hFC, 1'b0);

    // Back-pressure: 0x10 + 0x20 = 48, then an immediate next message 'A' = 65
    send1(8'h10, 1'b1, 1'b0);
    send1(8'h20, 1'b0, 1'b1);
    collect(2'd0, 56'h30_34_38, 3, 8'h30, 1'b1);
    send1(8'h41, 1'b1, 1'b1);
    collect(2'd0, 56'h30_36_35, 3, 8'h41, 1'b0);

    // Orphan beat in IDLE: err pulse, nothing emitted, next message clean (3)
    sel = 2'd0;
    send1(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    check1("orphan_err", m_err, 1'b1);
    check1("orphan_valid", m_valid, 1'b0);
    @(negedge clk);
    check1("orphan_err_clear", m_err, 1'b0);
    send1(8'h01, 1'b1, 1'b0);
    send1(8'h02, 1'b0, 1'b1);
    collect(2'd0, 56'h30_30_33, 3, 8'h03, 1'b0);

    // Sop mid-message: restart, 5 + 6 = 11
    sel = 2'd0;
    send1(8'h50, 1'b1, 1'b0);
    send1(8'h60, 1'b0, 1'b0);
    send1(8'h05, 1'b1, 1'b0);
    @(negedge clk);
    check1("restart_err", m_err, 1'b1);
    send1(8'h06, 1'b0, 1'b1);
    collect(2'd0, 56'h30_31_31, 3, 8'h0B, 1'b0);

    // Reset during emission
    sel = 2'd0;
    send1(8'h07, 1'b1, 1'b1);
    @(negedge clk);
    check1("pre_rst_valid", m_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1("midrst_valid", bus1.cks_valid, 1'b0);
    check1("midrst_last", bus1.cks_last, 1'b0);
    check1("midrst_inrdy", bus1.in_ready, 1'b0);
    check8("midrst_char", bus1.cks_char, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check1("postrst_inrdy", bus1.in_ready, 1'b1);
    check1("postrst_valid", bus1.cks_valid, 1'b0);
    send1(8'h43, 1'b1, 1'b1);
    collect(2'd0, 56'h30_36_37, 3, 8'h43, 1'b0);

    // 4-byte beat, keep 0011: 0x04 + 0x03 = 7
    send4(32'h01020304, 4'b0011, 1'b1, 1'b1);
    @(negedge clk);
    check1("b4_valid_t1", bus4.cks_valid, 1'b1);
    check1("b4t_valid_t1", bus4t.cks_valid, 1'b1);
    collect(2'd1, 56'h30_30_37, 3, 8'h07, 1'b0);
    collect(2'd2, 56'h31_30_3D_30_30_37_01, 7, 8'h07, 1'b0);

    // Full-width beat then an all-zero keep eop beat: 1020 -> 252
    send4(32'hFFFFFFFF, 4'b1111, 1'b1, 1'b0);
    send4(32'hDEADBEEF, 4'b0000, 1'b0, 1'b1);
    collect(2'd1, 56'h32_35_32, 3, 8'hFC, 1'b0);
    collect(2'd2, 56'h31_30_3D_32_35_32_01, 7, 8'hFC, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
